ysyx_22050854_divider: RTL and testbench

YSYX_22050854_DIVIDER -- requirements
Module: ysyx_22050854_divider

---
 rtl/ysyx_22050854_divider.sv | 128 ++++++++++++
 tb/tb_ysyx_22050854_divider.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/ysyx_22050854_divider.sv
// Iterative restoring divider for RV64 DIV/DIVU/REM/REMU and their 32-bit W forms.
// One quotient bit per cycle; divide-by-zero and signed overflow take a one-cycle path.
module ysyx_22050854_divider (
  input  logic        clock,
  input  logic        reset,
  input  logic [63:0] dividend,
  input  logic [63:0] divisor,
  input  logic        div_valid,
  input  logic        divw,
  input  logic        div_signed,
  input  logic        flush,
  output logic        div_ready,
  output logic        out_valid,
  output logic [63:0] quotient,
  output logic [63:0] remainder
);

  // state | meaning
  // IDLE  | waiting for a request, div_ready high
  // BUSY  | operands latched, iterating (or taking the special-case path)
  // DONE  | result registered, out_valid high for this one cycle
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state, state_nxt;
  logic [63:0] acc_q, acc_r, div_mag, a_ext;
  logic [6:0]  cnt;
  logic        op_w, neg_q, neg_r, special, div_zero;

  logic        accept, finish;
  logic [63:0] a_in, b_in, a_abs, b_abs;
  logic        a_neg, b_neg, zero_in, ovf_in;
  logic [64:0] shifted, trial;
  logic        ge;
  logic [63:0] q_sgn, r_sgn, res_q, res_r, fix_q, fix_r;

  assign accept = (state == IDLE) && div_valid && !flush;
  assign finish = (state == BUSY) && (special || (cnt == 7'd0));

  assign div_ready = (state == IDLE) && !reset;
  assign out_valid = (state == DONE);

  // Operand width handling: W forms use the low word, extended per signedness.
  always_comb begin
    a_in = dividend;
    b_in = divisor;
    if (divw) begin
      a_in = div_signed ? {{32{dividend[31]}}, dividend[31:0]} : {32'b0, dividend[31:0]};
      b_in = div_signed ? {{32{divisor[31]}}, divisor[31:0]}  : {32'b0, divisor[31:0]};
    end
  end

  assign a_neg   = div_signed && a_in[63];
  assign b_neg   = div_signed && b_in[63];
  assign a_abs   = a_neg ? (64'd0 - a_in) : a_in;
  assign b_abs   = b_neg ? (64'd0 - b_in) : b_in;
  assign zero_in = (b_in == 64'd0);
  assign ovf_in  = div_signed && (b_in == {64{1'b1}}) &&
                   (a_in == (divw ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));

  // Shifted partial remainder is at most 2*divisor, so bit 64 of the trial is its sign.
  assign shifted = {acc_r, acc_q[63]};
  assign trial   = shifted - {1'b0, div_mag};
  assign ge      = !trial[64];

  assign q_sgn = neg_q ? (64'd0 - acc_q) : acc_q;
  assign r_sgn = neg_r ? (64'd0 - acc_r) : acc_r;
  assign res_q = special ? (div_zero ? {64{1'b1}} : a_ext) : q_sgn;
  assign res_r = special ? (div_zero ? a_ext : 64'd0) : r_sgn;
  assign fix_q = op_w ? {{32{res_q[31]}}, res_q[31:0]} : res_q;
  assign fix_r = op_w ? {{32{res_r[31]}}, res_r[31:0]} : res_r;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = BUSY;
      BUSY: begin
        if (flush)       state_nxt = IDLE;
        else if (finish) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q     <= 64'd0;
      acc_r     <= 64'd0;
      div_mag   <= 64'd0;
      a_ext     <= 64'd0;
      cnt       <= 7'd0;
      op_w      <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      special   <= 1'b0;
      div_zero  <= 1'b0;
      quotient  <= 64'd0;
      remainder <= 64'd0;
    end else if (accept) begin
      // W forms start with the magnitude in the top word so 32 shifts drain it.
      acc_q    <= divw ? {a_abs[31:0], 32'b0} : a_abs;
      acc_r    <= 64'd0;
      div_mag  <= b_abs;
      a_ext    <= a_in;
      cnt      <= divw ? 7'd32 : 7'd64;
      op_w     <= divw;
      neg_q    <= a_neg ^ b_neg;
      neg_r    <= a_neg;
      special  <= zero_in | ovf_in;
      div_zero <= zero_in;
    end else if (state == BUSY && !flush) begin
      if (finish) begin
        quotient  <= fix_q;
        remainder <= fix_r;
      end else begin
        acc_r <= ge ? trial[63:0] : shifted[63:0];
        acc_q <= {acc_q[62:0], ge};
        cnt   <= cnt - 7'd1;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22050854_divider.sv
// Directed-vector bench for ysyx_22050854_divider: results, latency, flush and reset behaviour.
module tb_ysyx_22050854_divider;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] dividend = 64'd0;
  logic [63:0] divisor = 64'd0;
  logic        div_valid = 1'b0;
  logic        divw = 1'b0;
  logic        div_signed = 1'b0;
  logic        flush = 1'b0;
  logic        div_ready, out_valid;
  logic [63:0] quotient, remainder;

  int n_cmp = 0;
  int n_err = 0;

  ysyx_22050854_divider dut (
    .clock(clock), .reset(reset), .dividend(dividend), .divisor(divisor),
    .div_valid(div_valid), .divw(divw), .div_signed(div_signed), .flush(flush),
    .div_ready(div_ready), .out_valid(out_valid),
    .quotient(quotient), .remainder(remainder)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one request at the next edge, wait for out_valid and check result and latency.
  task automatic run_div(input string tag, input logic [63:0] a, input logic [63:0] b,
                         input logic w, input logic s, input logic hold,
                         input logic [63:0] eq, input logic [63:0] er, input int lat);
    int k = 0;
    @(negedge clock);
    dividend = a; divisor = b; divw = w; div_signed = s; div_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    if (!hold) div_valid = 1'b0;
    check({tag, " ready_busy"}, {63'd0, div_ready}, 64'd0);
    for (int i = 1; i <= 100; i++) begin
      @(posedge clock);
      @(negedge clock);
      if (out_valid) begin
        k = i;
        break;
      end
    end
    div_valid = 1'b0;
    check({tag, " latency"}, 64'(k), 64'(lat));
    check({tag, " quotient"}, quotient, eq);
    check({tag, " remainder"}, remainder, er);
    @(posedge clock);
    @(negedge clock);
    check({tag, " valid_once"}, {63'd0, out_valid}, 64'd0);
    check({tag, " ready_after"}, {63'd0, div_ready}, 64'd1);
  endtask

  task automatic count_valid(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clock);
      @(negedge clock);
      if (out_valid) cnt++;
    end
  endtask

  initial begin
    int pulses;

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst ready", {63'd0, div_ready}, 64'd0);
    check("rst valid", {63'd0, out_valid}, 64'd0);
    check("rst quotient", quotient, 64'd0);
    check("rst remainder", remainder, 64'd0);
    reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check("rst ready_after", {63'd0, div_ready}, 64'd1);

    run_div("divu 100/7", 64'd100, 64'd7, 1'b0, 1'b0, 1'b0, 64'd14, 64'd2, 65);
    run_div("div -7/2", 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b0, 1'b1, 1'b0,
            64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    run_div("div 7/-2", 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1, 1'b0,
            64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 65);
    run_div("divu max/16", 64'hFFFF_FFFF_FFFF_FFFF, 64'd16, 1'b0, 1'b0, 1'b0,
            64'h0FFF_FFFF_FFFF_FFFF, 64'd15, 65);
    run_div("divuw ffffffff/1", 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b1, 1'b0, 1'b0,
            64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 33);
    run_div("divw -20/6", 64'h1234_5678_FFFF_FFEC, 64'hAAAA_0000_0000_0006, 1'b1, 1'b1, 1'b0,
            64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFE, 33);
    run_div("divu by0", 64'h1234, 64'd0, 1'b0, 1'b0, 1'b0,
            64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 1);
    run_div("divw ovf", 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b1, 1'b0,
            64'hFFFF_FFFF_8000_0000, 64'd0, 1);
    run_div("div ovf64", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0,
            64'h8000_0000_0000_0000, 64'd0, 1);
    run_div("hold valid", 64'd50, 64'd5, 1'b0, 1'b0, 1'b1, 64'd10, 64'd0, 65);

    // Flush in IDLE blocks acceptance.
    @(negedge clock);
    dividend = 64'd1; divisor = 64'd1; div_valid = 1'b1; flush = 1'b1;
    @(posedge clock);
    @(negedge clock);
    div_valid = 1'b0; flush = 1'b0;
    check("idle flush ready", {63'd0, div_ready}, 64'd1);

    // Flush at BUSY cycle 10.
    dividend = 64'd1000; divisor = 64'd3; divw = 1'b0; div_signed = 1'b0; div_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    div_valid = 1'b0;
    repeat (9) @(posedge clock);
    @(negedge clock);
    flush = 1'b1;
    @(posedge clock);
    @(negedge clock);
    flush = 1'b0;
    check("flush ready", {63'd0, div_ready}, 64'd1);
    count_valid(80, pulses);
    check("flush no_valid", 64'(pulses), 64'd0);
    check("flush quotient_hold", quotient, 64'd10);
    run_div("divu 9/3", 64'd9, 64'd3, 1'b0, 1'b0, 1'b0, 64'd3, 64'd0, 65);

    // Reset at BUSY cycle 20 with div_valid held high.
    @(negedge clock);
    dividend = 64'd77; divisor = 64'd5; div_valid = 1'b1;
    @(posedge clock);
    repeat (19) @(posedge clock);
    @(negedge clock);
    reset = 1'b1; flush = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("reset ready", {63'd0, div_ready}, 64'd0);
    check("reset valid", {63'd0, out_valid}, 64'd0);
    check("reset quotient", quotient, 64'd0);
    check("reset remainder", remainder, 64'd0);
    reset = 1'b0; flush = 1'b0; div_valid = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check("reset ready_after", {63'd0, div_ready}, 64'd1);
    count_valid(80, pulses);
    check("reset no_valid", 64'(pulses), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
